muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving operand width in bits (even, >=4).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, request to begin an operation.
REQ-005 The block SHALL have port op, input, 2, operation: 0 MULT (signed), 1 MULTU, 2 DIV (signed), 3 DIVU.
REQ-006 The block SHALL have ports A and B, input, WIDTH, with A as multiplicand/dividend and B as multiplier/divisor.
REQ-007 The block SHALL have port busy, output, 1, high while an operation is in progress.
REQ-008 The block SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-009 The block SHALL have port div0, output, 1, set when a divide by zero is requested.
REQ-010 The block SHALL have ports HI and LO, output, WIDTH each, holding the result registers.

Function
REQ-011 The FSM SHALL have states IDLE, RUN, FIX and DONE.
REQ-012 Transitions SHALL be: IDLE->RUN on start; RUN->FIX after exactly WIDTH iterations; FIX->DONE; DONE->IDLE.
REQ-013 start SHALL be accepted only in IDLE and ignored in RUN, FIX and DONE.
REQ-014 On acceptance, A, B and op SHALL be latched; later input changes SHALL have no effect.
REQ-015 busy SHALL be 1 in RUN and FIX, and 0 in IDLE and DONE.
REQ-016 done SHALL be 1 only in DONE.
REQ-017 For start accepted at edge k, done SHALL be high in the cycle following edge k+WIDTH+2.
REQ-018 Multiply SHALL use radix-2 shift-add, one bit per RUN cycle, on operand magnitudes.
REQ-019 Multiply SHALL produce a full 2*WIDTH product, HI = upper half, LO = lower half.
REQ-020 Divide SHALL use restoring shift-subtract, one quotient bit per RUN cycle, on magnitudes.
REQ-021 Divide SHALL write LO = quotient and HI = remainder.
REQ-022 FIX SHALL apply sign correction; signed products are negated when operand signs differ.
REQ-023 Signed quotients SHALL be negated when operand signs differ, and signed remainders SHALL take the dividend's sign.
REQ-024 Signed DIV of the minimum value by -1 SHALL give LO = minimum value and HI = 0, with no flag.
REQ-025 HI and LO SHALL update only on the FIX->DONE edge and hold otherwise.
REQ-026 DIV/DIVU with latched B==0 SHALL go IDLE->DONE directly, set div0, leave HI/LO unchanged, and pulse done one cycle after acceptance.
REQ-027 div0 SHALL stay set until the next accepted start, which clears it.

Reset
REQ-028 Reset SHALL force state to IDLE, and busy, done, div0, HI, LO and internal registers to 0, immediately and independent of clk.
REQ-029 Reset during RUN or FIX SHALL abandon the operation with no done pulse.
REQ-030 start SHALL be ignored during reset and accepted at the first edge after reset deasserts.

Configuration
REQ-031 With MULDIV_ABORT_EN defined, the block SHALL add an input port abort, 1 bit.
REQ-032 With MULDIV_ABORT_EN defined, abort high in RUN or FIX SHALL return the FSM to IDLE at the next edge, with HI/LO/div0 unchanged and no done pulse.
REQ-033 With MULDIV_ABORT_EN defined, abort SHALL have priority over start and SHALL be ignored in IDLE and DONE.
REQ-034 Without MULDIV_ABORT_EN, port abort and its logic SHALL be absent and behaviour SHALL be otherwise identical.

Structure
REQ-035 Shared package muldiv_pkg SHALL hold the op encoding constants and the FSM state typedef.
REQ-036 Sub-module muldiv_iter SHALL implement one combinational multiply or divide iteration step, instantiated once.
REQ-037 The FSM, iteration counter and sign fix-up SHALL reside in muldiv_unit.

Verification (WIDTH=32)
REQ-038 MULTU with A = B = 0xFFFFFFFF SHALL give HI=0xFFFFFFFE, LO=0x00000001, with done exactly 34 cycles after the start edge.
REQ-039 MULT with A=0xFFFFFFFD (-3), B=5 SHALL give HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-040 DIV with A=0xFFFFFFF9 (-7), B=2 SHALL give LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-041 DIV with A=0x80000000, B=0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-042 DIVU with A=100, B=0 after a prior result SHALL give div0=1, done one cycle after acceptance, HI/LO unchanged; the next start SHALL clear div0.
REQ-043 Reset asserted in RUN cycle 10 SHALL give busy=0, HI=LO=0, no done.
REQ-044 With MULDIV_ABORT_EN, abort in RUN cycle 5 SHALL give IDLE next cycle and HI/LO unchanged.
REQ-045 A start asserted while busy SHALL be ignored.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Contents: operation encodings and the FSM state type.
// No logic here.
package muldiv_pkg;

  // Encodings on the op port
  localparam logic [1:0] OP_MULT  = 2'd0;  // signed multiply
  localparam logic [1:0] OP_MULTU = 2'd1;  // unsigned multiply
  localparam logic [1:0] OP_DIV   = 2'd2;  // signed divide
  localparam logic [1:0] OP_DIVU  = 2'd3;  // unsigned divide

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// One radix-2 step: shift-add multiply or restoring shift-subtract divide.
// Latency: purely combinational, no state.
// Backpressure: none; the caller decides when to register the step.
// Ports: is_div selects the step type; acc/q/m are the running upper half
//   (partial product / remainder), lower half (multiplier / dividend->quotient)
//   and the constant operand (multiplicand / divisor); acc_nxt/q_nxt are results.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] q_nxt
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  always_comb begin
    // Multiply: add multiplicand when the current multiplier bit is set, then
    // shift the {acc,q} pair right so the product fills in from the top.
    sum     = {1'b0, acc} + {1'b0, (q[0] ? m : {WIDTH{1'b0}})};
    // Divide: bring the next dividend bit into the remainder.
    shifted = {acc, q[WIDTH-1]};
    // When shifted >= m the true difference is below m, so W bits suffice.
    diff    = shifted[WIDTH-1:0] - m;
    acc_nxt = sum[WIDTH:1];
    q_nxt   = {sum[0], q[WIDTH-1:1]};
    if (is_div) begin
      if (shifted >= {1'b0, m}) begin
        acc_nxt = diff;
        q_nxt   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = shifted[WIDTH-1:0];
        q_nxt   = {q[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply and divide unit with HI/LO result registers.
// Latency: done pulses WIDTH+2 cycles after an accepted start (divide by zero: next cycle).
// Backpressure: start is accepted only in IDLE; while busy or in DONE it is ignored.
// Ports: clk, reset (async active-high), start/op/A/B request, busy, done, div0, HI, LO.
// Optional MULDIV_ABORT_EN adds input abort, which cancels a RUN/FIX operation.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef MULDIV_ABORT_EN
  input  logic             abort,
`endif
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH + 1) + 1;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_r;
  logic             neg_res;   // product / quotient needs negation
  logic             neg_rem;   // remainder takes the (negative) dividend sign
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             abort_hit;

  // op[0] clear means signed, op[1] set means divide.
  wire op_signed = ~op[0];
  wire op_div    = op[1];
  wire r_signed  = ~op_r[0];
  wire r_div     = op_r[1];

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .is_div  (r_div),
    .acc     (acc),
    .q       (q),
    .m       (m),
    .acc_nxt (acc_nxt),
    .q_nxt   (q_nxt)
  );

  // Sign fix-up of the magnitude result. Negating the minimum value wraps back
  // to itself, which gives the required min / -1 = min with remainder 0.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  assign prod_fix = neg_res ? -{acc, q} : {acc, q};
  assign quo_fix  = neg_res ? -q : q;
  assign rem_fix  = neg_rem ? -acc : acc;

`ifdef MULDIV_ABORT_EN
  assign abort_hit = abort && (state == RUN || state == FIX);
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      op_r    <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      acc     <= '0;
      q       <= '0;
      m       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      div0    <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      done <= 1'b0;
      if (abort_hit) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              // Raw operands are captured here and turned into magnitudes
              // in the first RUN cycle.
              op_r    <= op;
              q       <= A;
              m       <= B;
              acc     <= '0;
              cnt     <= '0;
              neg_res <= op_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
              neg_rem <= op_signed & op_div & A[WIDTH-1];
              div0    <= 1'b0;
              if (op_div && B == '0) begin
                div0  <= 1'b1;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                busy  <= 1'b1;
                state <= RUN;
              end
            end
          end
          RUN: begin
            // cnt 0: magnitude conversion; cnt 1..WIDTH: one iteration each.
            if (cnt == '0) begin
              if (r_signed && q[WIDTH-1]) q <= -q;
              if (r_signed && m[WIDTH-1]) m <= -m;
            end else begin
              acc <= acc_nxt;
              q   <= q_nxt;
            end
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH)) state <= FIX;
          end
          FIX: begin
            if (r_div) begin
              LO <= quo_fix;
              HI <= rem_fix;
            end else begin
              {HI, LO} <= prod_fix;
            end
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] A, B;
  logic         busy, done, div0;
  logic [W-1:0] HI, LO;
`ifdef MULDIV_ABORT_EN
  logic         abort;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int lat;
  bit saw_done;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
`ifdef MULDIV_ABORT_EN
    .abort (abort),
`endif
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .div0  (div0),
    .HI    (HI),
    .LO    (LO)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start is raised at a falling edge and dropped at the next, so it is
  // accepted at the rising edge in between. Operands are scrambled afterwards.
  task automatic do_start(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0; op = ~o; A = ~a; B = '0;
  endtask

  // lat = number of rising edges after the accepting edge before done is seen.
  task automatic wait_done(input int lat0, output int l);
    l = lat0;
    while (done !== 1'b1 && l < 200) begin
      @(negedge clk);
      l++;
    end
  endtask

  task automatic watch_no_done(input int cycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'd0; A = '0; B = '0;
`ifdef MULDIV_ABORT_EN
    abort = 1'b0;
`endif
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_div0", div0, 0);
    chk("rst_hi", HI, 0);
    chk("rst_lo", LO, 0);
    @(negedge clk);
    reset = 1'b0;

    // MULTU all ones
    do_start(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu_busy", busy, 1);
    wait_done(0, lat);
    chk("multu_lat", lat, 34);
    chk("multu_hi", HI, 32'hFFFFFFFE);
    chk("multu_lo", LO, 32'h00000001);
    chk("multu_busy_done", busy, 0);
    @(negedge clk);
    chk("multu_done_pulse", done, 0);

    // MULT -3 * 5
    do_start(2'd0, 32'hFFFFFFFD, 32'd5);
    wait_done(0, lat);
    chk("mult_lat", lat, 34);
    chk("mult_hi", HI, 32'hFFFFFFFF);
    chk("mult_lo", LO, 32'hFFFFFFF1);

    // MULT -4 * -6
    do_start(2'd0, 32'hFFFFFFFC, 32'hFFFFFFFA);
    wait_done(0, lat);
    chk("mult_nn_hi", HI, 32'h0);
    chk("mult_nn_lo", LO, 32'd24);

    // DIV -7 / 2
    do_start(2'd2, 32'hFFFFFFF9, 32'd2);
    wait_done(0, lat);
    chk("div_lat", lat, 34);
    chk("div_lo", LO, 32'hFFFFFFFD);
    chk("div_hi", HI, 32'hFFFFFFFF);

    // DIV 7 / -2
    do_start(2'd2, 32'd7, 32'hFFFFFFFE);
    wait_done(0, lat);
    chk("div_pn_lo", LO, 32'hFFFFFFFD);
    chk("div_pn_hi", HI, 32'd1);

    // DIV min / -1
    do_start(2'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_done(0, lat);
    chk("divmin_lo", LO, 32'h80000000);
    chk("divmin_hi", HI, 32'h0);
    chk("divmin_div0", div0, 0);

    // DIVU 100 / 7
    do_start(2'd3, 32'd100, 32'd7);
    wait_done(0, lat);
    chk("divu_lo", LO, 32'd14);
    chk("divu_hi", HI, 32'd2);

    // DIVU 100 / 0
    do_start(2'd3, 32'd100, 32'd0);
    chk("div0_flag", div0, 1);
    wait_done(0, lat);
    chk("div0_lat", lat, 0);
    chk("div0_lo_hold", LO, 32'd14);
    chk("div0_hi_hold", HI, 32'd2);
    chk("div0_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("div0_sticky", div0, 1);

    // MULTU 3*4 with a second start issued while busy
    do_start(2'd1, 32'd3, 32'd4);
    chk("div0_cleared", div0, 0);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 2'd3; A = 32'd100; B = 32'd0;
    @(negedge clk);
    start = 1'b0;
    wait_done(4, lat);
    chk("ign_lat", lat, 34);
    chk("ign_lo", LO, 32'd12);
    chk("ign_hi", HI, 32'd0);
    chk("ign_div0", div0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("ign_idle_busy", busy, 0);

    // Reset in RUN cycle 10 (preceded by a non-zero result)
    do_start(2'd2, 32'd7, 32'hFFFFFFFE);
    wait_done(0, lat);
    do_start(2'd1, 32'd5, 32'd6);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstrun_busy", busy, 0);
    chk("rstrun_hi", HI, 0);
    chk("rstrun_lo", LO, 0);
    chk("rstrun_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    watch_no_done(40, saw_done);
    chk("rstrun_no_done", saw_done, 0);

    // Start held through reset: ignored, then accepted at first edge after
    @(negedge clk);
    reset = 1'b1; start = 1'b1; op = 2'd1; A = 32'd2; B = 32'd3;
    @(negedge clk);
    chk("rststart_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("rststart_accept", busy, 1);
    wait_done(0, lat);
    chk("rststart_lat", lat, 34);
    chk("rststart_lo", LO, 32'd6);

`ifdef MULDIV_ABORT_EN
    // Abort in RUN cycle 5
    do_start(2'd1, 32'd7, 32'd7);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_lo", LO, 32'd6);
    chk("abort_hi", HI, 32'd0);
    watch_no_done(40, saw_done);
    chk("abort_no_done", saw_done, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
